// File: rtl/pc_pkg.sv
// Shared op-code constants for the program counter unit.
// The trap-on-stack-fault feature is enabled by defining PC_TRAP_EN.
package pc_pkg;

    localparam int PC_OP_W = 3;

    localparam logic [PC_OP_W-1:0] PC_OP_HOLD   = 3'd0;
    localparam logic [PC_OP_W-1:0] PC_OP_INC    = 3'd1;
    localparam logic [PC_OP_W-1:0] PC_OP_SKIP   = 3'd2;
    localparam logic [PC_OP_W-1:0] PC_OP_JUMP   = 3'd3;
    localparam logic [PC_OP_W-1:0] PC_OP_BRANCH = 3'd4;
    localparam logic [PC_OP_W-1:0] PC_OP_CALL   = 3'd5;
    localparam logic [PC_OP_W-1:0] PC_OP_RET    = 3'd6;
    localparam logic [PC_OP_W-1:0] PC_OP_RSVD   = 3'd7;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: DEPTH x ADDR_W, combinational top-of-stack read.
// Push when full and pop when empty are silently ignored.
module pc_ret_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp == SP_W'(i)) begin
                    mem[i] <= din;
                end
            end
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Top is the entry just below sp; reads 0 when empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_unit_stack.sv
// ADDR_W-bit program counter with call/return stack and sticky fault flag.
// Define PC_TRAP_EN to redirect stack faults to TRAP_VEC with a trap pulse.
module pc_unit_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 4,
    parameter int TRAP_VEC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [PC_OP_W-1:0]         op,
    input  logic [ADDR_W-1:0]          target,
    input  logic [ADDR_W-1:0]          offset,
    input  logic                       clr_err,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       err,
    output logic                       trap
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] fault_pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic              is_call;
    logic              is_ret;
    logic              fault;
    logic              push;
    logic              pop;

    pc_ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SP_W   (SP_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign is_call = en && (op == PC_OP_CALL);
    assign is_ret  = en && (op == PC_OP_RET);
    assign fault   = (is_call && stk_full)
                  || (is_ret && stk_empty);
    assign push    = is_call && !stk_full;
    assign pop     = is_ret && !stk_empty;
    assign pc_inc  = pc + ADDR_W'(1);

`ifdef PC_TRAP_EN
    assign fault_pc = ADDR_W'(TRAP_VEC);
`else
    assign fault_pc = pc_inc;
`endif

    always_comb begin
        pc_nxt = pc;
        unique case (1'b1)
            (op == PC_OP_INC):    pc_nxt = pc_inc;
            (op == PC_OP_SKIP):   pc_nxt = pc + ADDR_W'(2);
            (op == PC_OP_JUMP):   pc_nxt = target;
            (op == PC_OP_BRANCH): pc_nxt = pc + offset;
            (op == PC_OP_CALL):
                pc_nxt = stk_full ? fault_pc : target;
            (op == PC_OP_RET):
                pc_nxt = stk_empty ? fault_pc : top;
            default:              pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (en) begin
            pc <= pc_nxt;
        end
    end

    // A fault on the same edge beats a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fault) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap <= 1'b0;
        end else begin
            trap <= fault;
        end
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit_stack.sv
// Scoreboard bench for pc_unit_stack: directed cases then random ops
// against a queue-based reference model.
module tb_pc_unit_stack;

    localparam int TV = 8'h80;
`ifdef PC_TRAP_EN
    localparam bit TRAPON = 1'b1;
`else
    localparam bit TRAPON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] target = 8'd0;
    logic [7:0] offset = 8'd0;
    logic       clr_err = 1'b0;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       stk_full;
    logic       stk_empty;
    logic       err;
    logic       trap;

    pc_unit_stack #(
        .ADDR_W   (8),
        .DEPTH    (4),
        .TRAP_VEC (TV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .clr_err   (clr_err),
        .pc        (pc),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .err       (err),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int sp;
        int err;
        int trap;
    } exp_t;

    exp_t sb[$];
    int   mstk[$];
    int   mpc = 0;
    int   merr = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", int'(pc), e.pc);
            chk("sp", int'(sp), e.sp);
            chk("err", int'(err), e.err);
            chk("full", int'(stk_full), int'(e.sp == 4));
            chk("empty", int'(stk_empty), int'(e.sp == 0));
            chk("trap", int'(trap), e.trap);
        end
    end

    task automatic step(input bit e, input int o,
                        input int t = 0, input int off = 0,
                        input bit c = 1'b0);
        bit flt;
        en      = e;
        op      = 3'(o);
        target  = 8'(t);
        offset  = 8'(off);
        clr_err = c;
        @(posedge clk);
        flt = 1'b0;
        if (e) begin
            case (o)
                1: mpc = (mpc + 1) % 256;
                2: mpc = (mpc + 2) % 256;
                3: mpc = t % 256;
                4: mpc = (mpc + (off % 256)) % 256;
                5: begin
                    if (mstk.size() == 4) flt = 1'b1;
                    else begin
                        mstk.push_back((mpc + 1) % 256);
                        mpc = t % 256;
                    end
                end
                6: begin
                    if (mstk.size() == 0) flt = 1'b1;
                    else mpc = mstk.pop_back();
                end
                default: ;
            endcase
        end
        if (flt) begin
            mpc  = TRAPON ? TV : (mpc + 1) % 256;
            merr = 1;
        end else if (c) begin
            merr = 0;
        end
        sb.push_back('{mpc, mstk.size(), merr,
                       int'(flt && TRAPON)});
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_sp", int'(sp), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_full", int'(stk_full), 0);
        chk("rst_empty", int'(stk_empty), 1);
        chk("rst_trap", int'(trap), 0);
        mstk.delete();
        mpc  = 0;
        merr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        repeat (3) step(1, 1);
        step(1, 5, 8'h09);
        do_reset();
        step(1, 3, 8'hFF); step(1, 1);
        step(1, 3, 8'hFE); step(1, 2);
        step(1, 3, 8'h10); step(1, 4, 0, 8'hF0);
        step(1, 3, 8'h05); step(1, 5, 8'h40); step(1, 6);
        step(1, 5, 8'h10); step(1, 5, 8'h11);
        step(1, 5, 8'h12); step(1, 5, 8'h20);
        step(1, 5, 8'h60);
        step(1, 0, 0, 0, 1'b1);
        repeat (4) step(1, 6);
        step(1, 3, 8'h30); step(1, 6);
        step(0, 0, 0, 0, 1'b1);
        step(0, 3, 8'h55); step(1, 3, 8'h55);
        step(1, 7); step(1, 4, 0, 8'h7F);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0,
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)),
                     $urandom_range(0, 7) == 0);
            end
        end
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
